stonyman_frame_sequencer: RTL and testbench



---
 rtl/stonyman_pkg.sv | 28 ++
 rtl/stonyman_pulse_gen.sv | 69 ++++++
 rtl/stonyman_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_stonyman_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stonyman_pkg.sv
// Shared constants, pulse-select encoding and sequencer states for the
// Stonyman frame capture path.
package stonyman_pkg;

    localparam int REG_COLSEL = 0;
    localparam int REG_ROWSEL = 1;

    typedef enum logic [1:0] {
        PULSE_RESP = 2'd0,
        PULSE_INCP = 2'd1,
        PULSE_RESV = 2'd2,
        PULSE_INCV = 2'd3
    } pulse_sel_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ROW_PTR,
        ST_ROW_VAL,
        ST_COL_PTR,
        ST_COL_VAL,
        ST_SETTLE,
        ST_TRIGGER,
        ST_WAIT_DONE,
        ST_NEXT_COL,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/stonyman_pulse_gen.sv
// Drives one Stonyman sensor line high/low PULSE_CYCLES each, repeated i_count
// times; o_done marks the final low cycle so a chained go leaves no gap.
module stonyman_pulse_gen
    import stonyman_pkg::*;
#(
    parameter int PULSE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_go,
    input  pulse_sel_t i_sel,
    input  logic [7:0] i_count,
    output logic       o_resp,
    output logic       o_incp,
    output logic       o_resv,
    output logic       o_incv,
    output logic       o_done
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(PULSE_CYCLES - 1);

    logic            r_active;
    logic            r_high;
    logic [PW-1:0]   r_phaseCnt;
    logic [7:0]      r_left;
    pulse_sel_t      r_sel;
    logic            w_lineOn;

    // A new go always restarts the primitive, which lets the sequencer chain
    // the next pulse in the same cycle the previous one reports done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active   <= 1'b0;
            r_high     <= 1'b0;
            r_phaseCnt <= '0;
            r_left     <= '0;
            r_sel      <= PULSE_RESP;
        end else if (i_go) begin
            r_active   <= 1'b1;
            r_high     <= 1'b1;
            r_phaseCnt <= '0;
            r_left     <= i_count;
            r_sel      <= i_sel;
        end else if (r_active) begin
            if (r_phaseCnt == LAST_PHASE) begin
                r_phaseCnt <= '0;
                if (r_high) begin
                    r_high <= 1'b0;
                end else if (r_left <= 8'd1) begin
                    r_active <= 1'b0;
                end else begin
                    r_left <= r_left - 8'd1;
                    r_high <= 1'b1;
                end
            end else begin
                r_phaseCnt <= r_phaseCnt + PW'(1);
            end
        end
    end

    assign w_lineOn = r_active && r_high;
    assign o_resp   = w_lineOn && (r_sel == PULSE_RESP);
    assign o_incp   = w_lineOn && (r_sel == PULSE_INCP);
    assign o_resv   = w_lineOn && (r_sel == PULSE_RESV);
    assign o_incv   = w_lineOn && (r_sel == PULSE_INCV);
    assign o_done   = r_active && !r_high && (r_phaseCnt == LAST_PHASE) && (r_left <= 8'd1);

endmodule

// File: rtl/stonyman_frame_sequencer.sv
// Frame-level sequencer: walks the sensor row/column registers, settles,
// triggers adc_controller per pixel and reports frame completion.
module stonyman_frame_sequencer
    import stonyman_pkg::*;
#(
    parameter int ROWS          = 112,
    parameter int COLS          = 112,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_frame_start,
    input  logic          i_adc_capture_done,
    input  logic          i_fifo_full,
    output logic          o_adc_capture_start,
    output logic          o_resp,
    output logic          o_incp,
    output logic          o_resv,
    output logic          o_incv,
    output logic          o_frame_busy,
    output logic          o_frame_done,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);

    seq_state_t    r_state, w_nextState;
    logic          r_step, w_nextStep;
    logic [RW-1:0] r_row, w_nextRow;
    logic [CW-1:0] r_col, w_nextCol;
    logic [SW-1:0] r_settleCnt, w_nextSettle;
    logic          w_go;
    pulse_sel_t    w_sel;
    logic [7:0]    w_count;
    logic          w_pgDone;

    stonyman_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_pulseGen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_go    (w_go),
        .i_sel   (w_sel),
        .i_count (w_count),
        .o_resp  (o_resp),
        .o_incp  (o_incp),
        .o_resv  (o_resv),
        .o_incv  (o_incv),
        .o_done  (w_pgDone)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_step      <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_settleCnt <= '0;
        end else begin
            r_state     <= w_nextState;
            r_step      <= w_nextStep;
            r_row       <= w_nextRow;
            r_col       <= w_nextCol;
            r_settleCnt <= w_nextSettle;
        end
    end

    // Each pulse is launched in the cycle its predecessor (or the triggering
    // event) completes, so the sensor sees back-to-back pulses with no slack.
    always_comb begin
        w_nextState         = r_state;
        w_nextStep          = r_step;
        w_nextRow           = r_row;
        w_nextCol           = r_col;
        w_nextSettle        = r_settleCnt;
        w_go                = 1'b0;
        w_sel               = PULSE_RESP;
        w_count             = 8'd1;
        o_adc_capture_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_frame_start) begin
                    w_nextRow   = '0;
                    w_nextCol   = '0;
                    w_nextStep  = 1'b0;
                    w_go        = 1'b1;
                    w_nextState = ST_ROW_PTR;
                end
            end
            ST_ROW_PTR: begin
                if (w_pgDone) begin
                    w_go = 1'b1;
                    if (!r_step) begin
                        w_sel      = PULSE_INCP;
                        w_count    = 8'(REG_ROWSEL);
                        w_nextStep = 1'b1;
                    end else begin
                        w_sel       = PULSE_RESV;
                        w_nextStep  = 1'b0;
                        w_nextState = ST_ROW_VAL;
                    end
                end
            end
            ST_ROW_VAL: begin
                if (w_pgDone) begin
                    w_go = 1'b1;
                    if (!r_step && (r_row != '0)) begin
                        w_sel      = PULSE_INCV;
                        w_count    = 8'(r_row);
                        w_nextStep = 1'b1;
                    end else begin
                        w_nextStep  = 1'b0;
                        w_nextState = ST_COL_PTR;
                    end
                end
            end
            ST_COL_PTR: begin
                if (w_pgDone) begin
                    w_go        = 1'b1;
                    w_sel       = PULSE_RESV;
                    w_nextState = ST_COL_VAL;
                end
            end
            ST_COL_VAL, ST_NEXT_COL: begin
                if (w_pgDone) begin
                    w_nextSettle = '0;
                    w_nextState  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settleCnt == LAST_SETTLE) begin
                    w_nextState = ST_TRIGGER;
                end else begin
                    w_nextSettle = r_settleCnt + SW'(1);
                end
            end
            ST_TRIGGER: begin
                if (!i_fifo_full) begin
                    o_adc_capture_start = 1'b1;
                    w_nextState         = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_adc_capture_done) begin
                    if (r_col == LAST_COL) begin
                        if (r_row == LAST_ROW) begin
                            w_nextState = ST_DONE;
                        end else begin
                            w_nextRow   = r_row + RW'(1);
                            w_nextCol   = '0;
                            w_nextStep  = 1'b0;
                            w_go        = 1'b1;
                            w_nextState = ST_ROW_PTR;
                        end
                    end else begin
                        w_nextCol   = r_col + CW'(1);
                        w_go        = 1'b1;
                        w_sel       = PULSE_INCV;
                        w_nextState = ST_NEXT_COL;
                    end
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign o_frame_busy = (r_state != ST_IDLE);
    assign o_frame_done = (r_state == ST_DONE);
    assign o_row        = r_row;
    assign o_col        = r_col;

endmodule

// File: tb/tb_stonyman_frame_sequencer.sv
// Scoreboard bench for stonyman_frame_sequencer on a 2x3 frame with an
// adc_controller model answering 20 cycles after each capture start.
module tb_stonyman_frame_sequencer;

    localparam int ROWS    = 2;
    localparam int COLS    = 3;
    localparam int P       = 2;
    localparam int S       = 4;
    localparam int ADC_LAT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameStart = 1'b0;
    logic       fifoFull = 1'b0;
    logic       modelDone = 1'b0;
    logic       spurDone = 1'b0;
    logic       adcDone;
    logic       captureStart, resp, incp, resv, incv, frameBusy, frameDone;
    logic [0:0] row;
    logic [1:0] col;
    logic [3:0] lines;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int highLen[4];
    int riseCnt[4];
    int bRise[4];
    int gap = 100;
    int lastHigh = 0;
    int lastFull = -100;
    int lastAdcDone = 0;
    int doneAt = -1;
    int respAt = -1;
    int startCnt = 0;
    int doneCnt = 0;
    int bStart, bDone, savedDone, expTrig;
    bit abortNext = 0;
    bit expectBusy = 0;
    logic [3:0] prevLines = '0;
    logic [2:0] expPix;
    logic [2:0] sbQ[$];

    assign adcDone = modelDone | spurDone;
    assign lines   = {resp, incp, resv, incv};

    stonyman_frame_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_frame_start       (frameStart),
        .i_adc_capture_done  (adcDone),
        .i_fifo_full         (fifoFull),
        .o_adc_capture_start (captureStart),
        .o_resp              (resp),
        .o_incp              (incp),
        .o_resv              (resv),
        .o_incv              (incv),
        .o_frame_busy        (frameBusy),
        .o_frame_done        (frameDone),
        .o_row               (row),
        .o_col               (col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rs, input logic sp, input logic ff);
        @(posedge clk);
        #1;
        frameStart = st;
        reset      = rs;
        spurDone   = sp;
        fifoFull   = ff;
    endtask

    task automatic startFrame();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic snap();
        bStart = startCnt;
        bDone  = doneCnt;
        for (int i = 0; i < 4; i++) bRise[i] = riseCnt[i];
    endtask

    task automatic waitAdcDones(input int n);
        int got = 0;
        for (int t = 0; t < 2000 && got < n; t++) begin
            @(negedge clk);
            if (modelDone) got++;
        end
        checkOutput("adcDoneSeen", got, n);
    endtask

    task automatic waitStarts(input int target);
        for (int t = 0; t < 2000 && startCnt < target; t++) @(negedge clk);
        checkOutput("startsSeen", int'(startCnt >= target), 1);
    endtask

    task automatic waitFrameDone();
        for (int t = 0; t < 3000 && doneCnt <= bDone; t++) @(negedge clk);
        checkOutput("frameDoneSeen", int'(doneCnt > bDone), 1);
    endtask

    task automatic checkFrame();
        checkOutput("startCount", startCnt - bStart, ROWS * COLS);
        checkOutput("frameDoneCount", doneCnt - bDone, 1);
        checkOutput("respCount", riseCnt[3] - bRise[3], 4);
        checkOutput("incpCount", riseCnt[2] - bRise[2], 2);
        checkOutput("resvCount", riseCnt[1] - bRise[1], 4);
        checkOutput("incvCount", riseCnt[0] - bRise[0], 5);
        checkOutput("sbDrained", sbQ.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            modelDone = (cyc == doneAt);
        end
    end

    // Monitor and scoreboard: everything here samples on the falling edge.
    always @(negedge clk) begin
        if (abortNext) begin
            checkOutput("resetOutputs",
                        int'({captureStart, lines, frameBusy, frameDone, row, col}), 0);
            prevLines = '0;
            for (int i = 0; i < 4; i++) highLen[i] = 0;
            gap = 100;
            abortNext = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lines[i] && !prevLines[i]) begin
                    riseCnt[i]++;
                    checkOutput("pulseLowGap", int'(gap >= P), 1);
                end
                if (lines[i]) begin
                    highLen[i]++;
                end else if (prevLines[i]) begin
                    checkOutput("pulseHighLen", highLen[i], P);
                    highLen[i] = 0;
                end
            end
            if (lines != 4'd0) begin
                checkOutput("oneLineHigh", $countones(lines), 1);
                gap = 0;
                lastHigh = cyc;
            end else begin
                gap++;
            end
            prevLines = lines;
            if (cyc == respAt) checkOutput("respAfterStart", int'(resp), 1);
            checkOutput("frameBusy", int'(frameBusy), int'(expectBusy));
            if (captureStart) begin
                expTrig = lastHigh + P + S + 1;
                if (lastFull >= expTrig) expTrig = lastFull + 1;
                checkOutput("triggerCycle", cyc, expTrig);
                checkOutput("sbQueued", int'(sbQ.size() > 0), 1);
                if (sbQ.size() > 0) begin
                    expPix = sbQ.pop_front();
                    checkOutput("pixelRowCol", int'({row, col}), int'(expPix));
                end
                doneAt = cyc + ADC_LAT;
                startCnt++;
            end
            if (frameDone) begin
                doneCnt++;
                checkOutput("frameDoneLatency", cyc - lastAdcDone, 1);
                expectBusy = 0;
            end
        end
        if (modelDone) lastAdcDone = cyc;
        if (fifoFull) lastFull = cyc;
        if (frameStart && !expectBusy && !reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    sbQ.push_back({1'(r), 2'(c)});
            expectBusy = 1;
            respAt = cyc + 1;
        end
        if (reset) begin
            abortNext = 1;
            expectBusy = 0;
            doneAt = -1;
            sbQ.delete();
        end
    end

    initial begin
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] frame 1: plain capture");
        snap();
        startFrame();
        waitFrameDone();
        checkFrame();
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] frame 2: fifo stall at third trigger");
        snap();
        startFrame();
        waitAdcDones(2);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitFrameDone();
        checkFrame();
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] frame 3: spurious done in settle, frame_start while busy");
        snap();
        startFrame();
        waitAdcDones(1);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        startFrame();
        waitFrameDone();
        repeat (40) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkFrame();

        $display("[TB] frame 4: reset during capture of pixel (0,1), then full frame");
        snap();
        startFrame();
        waitStarts(bStart + 2);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        savedDone = bDone;
        snap();
        bDone = savedDone;
        startFrame();
        waitFrameDone();
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkFrame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
